// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for the bit-serial adder: captures {a, b, cin}, clears the adder, then streams LSB-first.
// Optional FEEDER_PRELOAD_EN adds a one-entry holding buffer so words can run back-to-back.
module serial_operand_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             adder_clr,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               cin_q, cin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               xfer;
  logic               last_bit;

`ifdef FEEDER_PRELOAD_EN
  logic [WIDTH-1:0]   buf_a_q, buf_a_d;
  logic [WIDTH-1:0]   buf_b_q, buf_b_d;
  logic               buf_cin_q, buf_cin_d;
  logic               buf_full_q, buf_full_d;

  assign in_ready = !buf_full_q;
`else
  assign in_ready = (state_q == ST_IDLE);
`endif

  assign xfer     = in_valid && in_ready;
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef FEEDER_PRELOAD_EN
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    buf_cin_d  = buf_cin_q;
    buf_full_d = buf_full_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          cin_d   = in_cin;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          // The final bit is not shifted out, so ser_a/ser_b keep showing it while idle.
          done_d  = 1'b1;
          state_d = ST_IDLE;
`ifdef FEEDER_PRELOAD_EN
          if (buf_full_q) begin
            a_sh_d     = buf_a_q;
            b_sh_d     = buf_b_q;
            cin_d      = buf_cin_q;
            cnt_d      = '0;
            buf_full_d = 1'b0;
            state_d    = ST_CLEAR;
          end else if (xfer) begin
            a_sh_d  = in_a;
            b_sh_d  = in_b;
            cin_d   = in_cin;
            cnt_d   = '0;
            state_d = ST_CLEAR;
          end
`endif
        end else begin
          a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef FEEDER_PRELOAD_EN
    // Words accepted while a word is in flight park in the buffer; the last cycle takes them directly.
    if (xfer && (state_q != ST_IDLE) && !last_bit) begin
      buf_a_d    = in_a;
      buf_b_d    = in_b;
      buf_cin_d  = in_cin;
      buf_full_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef FEEDER_PRELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_a_q    <= '0;
      buf_b_q    <= '0;
      buf_cin_q  <= 1'b0;
      buf_full_q <= 1'b0;
    end else begin
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
      buf_cin_q  <= buf_cin_d;
      buf_full_q <= buf_full_d;
    end
  end
`endif

  assign adder_clr = (state_q == ST_CLEAR);
  assign ser_a     = a_sh_q[0];
  assign ser_b     = b_sh_q[0];
  assign ser_cin   = cin_q;
  assign ser_first = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign ser_last  = last_bit;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Self-checking bench for serial_operand_feeder: directed words, reset abort, and 200 random words
// checked against a word-level model plus a behavioural serial adder fed from ser_*.
module tb_serial_operand_feeder;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } word_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         adder_clr;
  logic         ser_a;
  logic         ser_b;
  logic         ser_cin;
  logic         ser_first;
  logic         ser_last;
  logic         busy;
  logic         done;

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .adder_clr (adder_clr),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_cin   (ser_cin),
    .ser_first (ser_first),
    .ser_last  (ser_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Words accepted by the DUT but not yet started (popped when their clear cycle appears).
  word_t q[$];
  int    xfers   = 0;
  int    aborts  = 0;

  // Monitor / reference model state.
  int           phase = -1;
  bit           done_pending = 1'b0;
  word_t        cur;
  logic         carry_m;
  logic [W-1:0] sum_m;
  logic         held_a = 1'b0, held_b = 1'b0, held_cin = 1'b0;
  int           done_seen  = 0;
  int           words_done = 0;

  always @(negedge clk) begin
    bit           exp_clr;
    bit           in_word;
    int           k;
    logic [W:0]   exp_sum;
    if (rst) begin
      chk("rst_adder_clr", adder_clr, 0);
      chk("rst_ser_a", ser_a, 0);
      chk("rst_ser_b", ser_b, 0);
      chk("rst_ser_cin", ser_cin, 0);
      chk("rst_ser_first", ser_first, 0);
      chk("rst_ser_last", ser_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 1);
      phase        = -1;
      done_pending = 1'b0;
      held_a       = 1'b0;
      held_b       = 1'b0;
      held_cin     = 1'b0;
      q.delete();
    end else begin
      chk("done", done, done_pending);
      if (done) done_seen++;
      done_pending = 1'b0;
      exp_clr = (phase < 0) && (q.size() > 0);
      in_word = exp_clr || (phase >= 0);
      chk("adder_clr", adder_clr, exp_clr);
      if (exp_clr) begin
        cur = q.pop_front();
        chk("clr_ser_a_bit0", ser_a, cur.a[0]);
        chk("clr_ser_b_bit0", ser_b, cur.b[0]);
        chk("clr_ser_cin", ser_cin, cur.cin);
        chk("clr_ser_first", ser_first, 0);
        chk("clr_ser_last", ser_last, 0);
        chk("clr_busy", busy, 1);
        carry_m = cur.cin;
        sum_m   = '0;
        phase   = 0;
      end else if (phase >= 0) begin
        k = phase;
        chk("ser_a", ser_a, cur.a[k]);
        chk("ser_b", ser_b, cur.b[k]);
        chk("ser_cin", ser_cin, cur.cin);
        chk("ser_first", ser_first, (k == 0));
        chk("ser_last", ser_last, (k == W - 1));
        chk("shift_busy", busy, 1);
        // Downstream serial adder, driven only by what the feeder presents.
        sum_m[k] = ser_a ^ ser_b ^ carry_m;
        carry_m  = (ser_a & ser_b) | (ser_a & carry_m) | (ser_b & carry_m);
        if (k == W - 1) begin
          exp_sum = {1'b0, cur.a} + {1'b0, cur.b} + {{W{1'b0}}, cur.cin};
          chk("word_sum", {carry_m, sum_m}, exp_sum);
          held_a       = cur.a[W-1];
          held_b       = cur.b[W-1];
          held_cin     = cur.cin;
          phase        = -1;
          done_pending = 1'b1;
          words_done++;
        end else begin
          phase++;
        end
      end else begin
        chk("idle_busy", busy, 0);
        chk("idle_ser_first", ser_first, 0);
        chk("idle_ser_last", ser_last, 0);
        chk("idle_hold_a", ser_a, held_a);
        chk("idle_hold_b", ser_b, held_b);
        chk("idle_hold_cin", ser_cin, held_cin);
      end
`ifdef FEEDER_PRELOAD_EN
      chk("in_ready", in_ready, (q.size() == 0));
`else
      chk("in_ready", in_ready, !in_word);
`endif
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int    waited;
    word_t w;
    waited = 0;
    @(negedge clk); #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    while (!in_ready && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    if (waited >= 100) begin
      chk("xfer_timeout", 1, 0);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      w.a   = a;
      w.b   = b;
      w.cin = c;
      q.push_back(w);
      xfers++;
    end
  endtask

  // Idle cycles: offers junk only while in_ready is low, then withdraws it.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_cin   = 1'($urandom);
      in_valid = !in_ready && ($urandom_range(0, 1) == 1);
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int waited;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Directed word 1011 + 0110 + 1.
    send(4'b1011, 4'b0110, 1'b1);
    idle(8);

    // Source keeps in_valid up while the feeder is busy.
    send(4'b0101, 4'b1001, 1'b0);
    send(4'b1110, 4'b0011, 1'b1);
    idle(8);

    // Reset in the middle of bit 2 aborts the word.
    send(4'b1101, 4'b0111, 1'b1);
    @(negedge clk); #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    aborts++;
    @(negedge clk); #1 rst = 1'b0;
    idle(2);
    send(4'b1001, 4'b1100, 1'b0);
    idle(8);

    // Back-to-back pair (buffered when the holding buffer is present).
    send(4'hF, 4'h1, 1'b0);
    send(4'h3, 4'hC, 1'b1);
    idle(14);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    @(negedge clk); #1 in_valid = 1'b0;

    waited = 0;
    while ((q.size() != 0 || phase >= 0 || done_pending) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    chk("drain_timeout", (waited >= 200), 0);
    chk("words_done", words_done, xfers - aborts);
    chk("done_count", done_seen, words_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
